// File: rtl/ahbl_sram_responder_if.sv
// AHB-Lite bus bundle for the SRAM responder slot.
// The master modport is the fabric side. The slave modport is the responder side.
interface ahbl_sram_responder_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/ahbl_sram_responder.sv
// AHB-Lite subordinate in front of a banked, single-port, 1-cycle-latency SRAM.
// Reads have zero wait states. A write's data phase owns the SRAM port, so a read
// accepted during that phase is stalled one cycle.
// Optional build macro AHBL_SRAM_ERR_EN: misaligned transfers get a two-cycle ERROR
// response. Without it, HRESP is tied low.
module ahbl_sram_responder #(
  parameter int unsigned AW    = 15,
  parameter int unsigned NBANK = 4
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  ahbl_sram_responder_if.slave bus,
  input  logic [31:0]          SRAMRDATA,
  output logic [3:0]           SRAMWEN,
  output logic [31:0]          SRAMWDATA,
  output logic [NBANK-1:0]     SRAMCS,
  output logic [AW-1:0]        SRAMADDR
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD, S_RDW, S_ERR1, S_ERR2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_bank;
  logic [AW-1:0]    r_addr;
  logic [3:0]       r_lanes;
  logic             r_rd_ok;
  logic             r_hreadyout;
  logic             r_hresp;

  logic             w_valid;
  logic             w_accept;
  logic             w_err;
  logic [1:0]       w_bank;
  logic [AW-1:0]    w_waddr;
  logic [3:0]       w_lanes;
  logic [NBANK-1:0] w_sel_h;
  logic [NBANK-1:0] w_sel_r;
  logic             w_unused;

  // Bank indices with no populated bank decode to an all-zero select.
  function automatic logic [NBANK-1:0] f_bank_sel(input logic [1:0] bank);
    logic [NBANK-1:0] sel;
    sel = '0;
    for (int unsigned i = 0; i < NBANK; i++) begin
      sel[i] = (32'(bank) == i);
    end
    return sel;
  endfunction

  assign w_valid  = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign w_accept = w_valid & r_hreadyout;
  assign w_bank   = bus.HADDR[AW+3:AW+2];
  assign w_waddr  = bus.HADDR[AW+1:2];
  assign w_sel_h  = f_bank_sel(w_bank);
  assign w_sel_r  = f_bank_sel(r_bank);

`ifdef AHBL_SRAM_ERR_EN
  assign w_err = ((bus.HSIZE == 3'd1) && bus.HADDR[0]) ||
                 ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00)) ||
                 (bus.HSIZE > 3'd2);
  assign bus.HRESP = r_hresp;
  assign w_unused  = ^{bus.HADDR[31:AW+4], bus.HTRANS[0]};
`else
  assign w_err     = 1'b0;
  assign bus.HRESP = 1'b0;
  assign w_unused  = ^{bus.HADDR[31:AW+4], bus.HTRANS[0], r_hresp};
`endif

  // Byte-lane mask from transfer size and the low address bits. Any size above word is a full word.
  always_comb begin
    w_lanes = 4'b1111;
    case (bus.HSIZE)
      3'd0:    w_lanes = 4'b0001 << bus.HADDR[1:0];
      3'd1:    w_lanes = 4'b0011 << {bus.HADDR[1], 1'b0};
      default: w_lanes = 4'b1111;
    endcase
  end

  // Transfer FSM with registered ready and response.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= S_IDLE;
      r_bank      <= '0;
      r_addr      <= '0;
      r_lanes     <= '0;
      r_rd_ok     <= 1'b0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
    end else begin
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      if (w_accept && w_err) begin
        r_state     <= S_ERR1;
        r_hreadyout <= 1'b0;
        r_hresp     <= 1'b1;
      end else if (w_accept && bus.HWRITE) begin
        r_state <= S_WR;
        r_bank  <= w_bank;
        r_addr  <= w_waddr;
        r_lanes <= w_lanes;
      end else if (w_accept) begin
        if (r_state == S_WR) begin
          // The SRAM port is busy with the write data phase. Park the read and issue it from RDW.
          r_state     <= S_RDW;
          r_bank      <= w_bank;
          r_addr      <= w_waddr;
          r_hreadyout <= 1'b0;
        end else begin
          r_state <= S_RD;
          r_rd_ok <= |w_sel_h;
        end
      end else begin
        case (r_state)
          S_RDW: begin
            r_state <= S_RD;
            r_rd_ok <= |w_sel_r;
          end
          S_ERR1: begin
            r_state <= S_ERR2;
            r_hresp <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // SRAM port steering. It is held idle during reset so that an abandoned write never lands.
  always_comb begin
    SRAMCS   = '0;
    SRAMWEN  = '0;
    SRAMADDR = w_waddr;
    if (!HRESET) begin
      case (r_state)
        S_WR: begin
          SRAMCS   = w_sel_r;
          SRAMADDR = r_addr;
          SRAMWEN  = (|w_sel_r) ? r_lanes : 4'b0000;
        end
        S_RDW: begin
          SRAMCS   = w_sel_r;
          SRAMADDR = r_addr;
        end
        default: begin
          if (w_accept && !bus.HWRITE && !w_err) begin
            SRAMCS = w_sel_h;
          end
        end
      endcase
    end
  end

  assign SRAMWDATA     = bus.HWDATA;
  assign bus.HREADYOUT = r_hreadyout;
  assign bus.HRDATA    = ((r_state == S_RD) && r_rd_ok) ? SRAMRDATA : '0;

endmodule

// File: tb/tb_ahbl_sram_responder.sv
// Self-checking bench for ahbl_sram_responder with a behavioural banked SRAM.
// It has a pipelined AHB-Lite driver and a read-data scoreboard.
`timescale 1ns/1ps
module tb_ahbl_sram_responder;
  localparam int unsigned AW    = 15;
  localparam int unsigned NBANK = 4;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [31:0]   SRAMRDATA;
  logic [3:0]    SRAMWEN;
  logic [31:0]   SRAMWDATA;
  logic [3:0]    SRAMCS;
  logic [AW-1:0] SRAMADDR;

  ahbl_sram_responder_if bus ();

  ahbl_sram_responder #(.AW(AW), .NBANK(NBANK)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .bus       (bus),
    .SRAMRDATA (SRAMRDATA),
    .SRAMWEN   (SRAMWEN),
    .SRAMWDATA (SRAMWDATA),
    .SRAMCS    (SRAMCS),
    .SRAMADDR  (SRAMADDR)
  );

  always #5 HCLK = ~HCLK;
  assign bus.HREADY = bus.HREADYOUT;

  // Behavioural SRAM: 4 banks of 2^AW words. The key is {bank, word}.
  logic [31:0] sram_mem [0:(1<<17)-1];
  logic [16:0] w_key;
  logic [31:0] w_mask;
  logic        pre_en;
  logic [16:0] pre_key;
  logic [31:0] pre_data;

  always_comb begin
    w_key = {2'b00, SRAMADDR};
    for (int b = 0; b < 4; b++) begin
      if (SRAMCS[b]) w_key[16:15] = 2'(b);
    end
  end
  assign w_mask = {{8{SRAMWEN[3]}}, {8{SRAMWEN[2]}}, {8{SRAMWEN[1]}}, {8{SRAMWEN[0]}}};

  always @(posedge HCLK) begin
    if (pre_en) begin
      sram_mem[pre_key] <= pre_data;
    end else if (SRAMCS != 4'b0000) begin
      if (SRAMWEN != 4'b0000) sram_mem[w_key] <= (sram_mem[w_key] & ~w_mask) | (SRAMWDATA & w_mask);
      else                    SRAMRDATA <= sram_mem[w_key];
    end
  end

  typedef struct {
    logic        vld;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic [31:0] data;
    int unsigned waits;
  } exp_t;

  txn_t        txq[$];
  exp_t        sb[$];
  txn_t        dp;
  logic [31:0] ref_mem [int];
  int unsigned stall;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] lanes_of(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'd0:    return (a == 2'd0) ? 4'b0001 : (a == 2'd1) ? 4'b0010 : (a == 2'd2) ? 4'b0100 : 4'b1000;
      3'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] addr);
    int k;
    k = int'(addr[18:2]);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  task automatic ref_wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    logic [3:0]  l;
    logic [31:0] m;
    l = lanes_of(size, addr[1:0]);
    m = {{8{l[3]}}, {8{l[2]}}, {8{l[1]}}, {8{l[0]}}};
    ref_mem[int'(addr[18:2])] = (ref_rd(addr) & ~m) | (data & m);
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    @(negedge HCLK);
    pre_en   = 1'b1;
    pre_key  = addr[18:2];
    pre_data = data;
    @(negedge HCLK);
    pre_en = 1'b0;
    ref_mem[int'(addr[18:2])] = data;
  endtask

  task automatic q_wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    txq.push_back('{vld: 1'b1, wr: 1'b1, addr: addr, size: size, data: data});
  endtask

  task automatic q_rd(input logic [31:0] addr, input logic [2:0] size);
    txq.push_back('{vld: 1'b1, wr: 1'b0, addr: addr, size: size, data: 32'h0});
  endtask

  task automatic q_idle();
    txq.push_back('{vld: 1'b0, wr: 1'b0, addr: 32'h0, size: 3'd0, data: 32'h0});
  endtask

  task automatic drive_ap(input txn_t t);
    bus.HSEL   = t.vld;
    bus.HTRANS = t.vld ? 2'b10 : 2'b00;
    bus.HWRITE = t.wr;
    bus.HADDR  = t.addr;
    bus.HSIZE  = t.size;
  endtask

  // Completes the data phase in flight. It is called at the negedge of a cycle with HREADYOUT=1.
  task automatic finish_dp();
    exp_t       e;
    logic [3:0] exp_cs;
    chk_eq("hresp", 32'(bus.HRESP), 32'h0);
    if (dp.wr) begin
      exp_cs = 4'b0000;
      exp_cs[dp.addr[18:17]] = 1'b1;
      chk_eq("wr_wen", 32'(SRAMWEN), 32'(lanes_of(dp.size, dp.addr[1:0])));
      chk_eq("wr_cs", 32'(SRAMCS), 32'(exp_cs));
      chk_eq("wr_addr", 32'(SRAMADDR), 32'(dp.addr[16:2]));
    end else if (sb.size() == 0) begin
      chk_eq("sb_underflow", 32'(sb.size()), 32'h1);
    end else begin
      e = sb.pop_front();
      chk_eq("rd_data", bus.HRDATA, e.data);
      chk_eq("rd_waits", 32'(stall), 32'(e.waits));
    end
  endtask

  task automatic run_bus();
    txn_t        ap;
    exp_t        e;
    int unsigned guard;
    guard = 0;
    while ((txq.size() > 0 || dp.vld) && guard < 500) begin
      @(negedge HCLK);
      guard++;
      if (bus.HREADYOUT) begin
        if (dp.vld) finish_dp();
        if (txq.size() > 0) ap = txq.pop_front();
        else ap = '{vld: 1'b0, wr: 1'b0, addr: 32'h0, size: 3'd0, data: 32'h0};
        drive_ap(ap);
        bus.HWDATA = dp.data;
        if (ap.vld && ap.wr) begin
          ref_wr(ap.addr, ap.size, ap.data);
        end else if (ap.vld) begin
          e.data  = ref_rd(ap.addr);
          e.waits = (dp.vld && dp.wr) ? 1 : 0;
          sb.push_back(e);
        end
        dp    = ap;
        stall = 0;
      end else if (dp.vld) begin
        stall++;
      end
    end
    chk_eq("bus_drained", 32'(txq.size()) + 32'(dp.vld), 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1;
    pre_en = 1'b0;
    pre_key = '0;
    pre_data = '0;
    dp = '{vld: 1'b0, wr: 1'b0, addr: 32'h0, size: 3'd0, data: 32'h0};
    stall = 0;
    drive_ap(dp);
    bus.HWDATA = 32'h0;

    // Reset values after one edge with HRESET high.
    @(posedge HCLK);
    #1;
    chk_eq("rst_hreadyout", 32'(bus.HREADYOUT), 32'h1);
    chk_eq("rst_hresp", 32'(bus.HRESP), 32'h0);
    chk_eq("rst_hrdata", bus.HRDATA, 32'h0);
    chk_eq("rst_cs", 32'(SRAMCS), 32'h0);
    chk_eq("rst_wen", 32'(SRAMWEN), 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;

    for (int i = 0; i < 4; i++) preload(32'(i * 4), 32'hA0A0_0000 + 32'(i));

    // Word write, an idle cycle, then a read-back with zero waits.
    q_wr(32'h10, 3'd2, 32'hDEADBEEF); q_idle(); q_rd(32'h10, 3'd2);
    run_bus();

    // Byte write to lane 3 over a preloaded word.
    preload(32'h10, 32'h11223344);
    q_wr(32'h13, 3'd0, 32'hAAAAAAAA); q_idle(); q_rd(32'h10, 3'd2);
    run_bus();

    // Write immediately followed by a read of the same word, with one wait state.
    q_wr(32'h20, 3'd2, 32'h5A5A5A5A); q_rd(32'h20, 3'd2);
    run_bus();

    // Four back-to-back reads of preloaded words.
    q_rd(32'h0, 3'd2); q_rd(32'h4, 3'd2); q_rd(32'h8, 3'd2); q_rd(32'hC, 3'd2);
    run_bus();

    // Write to bank 1, word 0, then read it back.
    q_wr(32'h0002_0000, 3'd2, 32'h12345678); q_idle(); q_rd(32'h0002_0000, 3'd2);
    run_bus();

    // Write-write-write streaming, a halfword lane merge, then reads.
    preload(32'h28, 32'h87654321);
    q_wr(32'h30, 3'd2, 32'h0BADF00D); q_wr(32'h34, 3'd2, 32'h600DCAFE);
    q_wr(32'h2A, 3'd1, 32'hBEEFBEEF);
    q_rd(32'h30, 3'd2); q_rd(32'h34, 3'd2); q_rd(32'h28, 3'd2);
    run_bus();

`ifdef AHBL_SRAM_ERR_EN
    // Misaligned word read gives a two-cycle ERROR response and no SRAM access.
    @(negedge HCLK);
    drive_ap('{vld: 1'b1, wr: 1'b0, addr: 32'h2, size: 3'd2, data: 32'h0});
    #1;
    chk_eq("err_cs", 32'(SRAMCS), 32'h0);
    @(negedge HCLK);
    chk_eq("err1_hresp", 32'(bus.HRESP), 32'h1);
    chk_eq("err1_ready", 32'(bus.HREADYOUT), 32'h0);
    chk_eq("err1_cs", 32'(SRAMCS), 32'h0);
    drive_ap('{vld: 1'b0, wr: 1'b0, addr: 32'h0, size: 3'd0, data: 32'h0});
    @(negedge HCLK);
    chk_eq("err2_hresp", 32'(bus.HRESP), 32'h1);
    chk_eq("err2_ready", 32'(bus.HREADYOUT), 32'h1);
    @(negedge HCLK);
    chk_eq("err_done_hresp", 32'(bus.HRESP), 32'h0);
`else
    // A misaligned word read truncates to the enclosing word.
    q_rd(32'h2, 3'd2);
    run_bus();
`endif

    // Reset asserted in the write data phase abandons the write.
    preload(32'h40, 32'h01020304);
    @(negedge HCLK);
    drive_ap('{vld: 1'b1, wr: 1'b1, addr: 32'h40, size: 3'd2, data: 32'h0});
    @(negedge HCLK);
    chk_eq("rstwr_wen_before", 32'(SRAMWEN), 32'hF);
    drive_ap('{vld: 1'b0, wr: 1'b0, addr: 32'h0, size: 3'd0, data: 32'h0});
    bus.HWDATA = 32'hCAFEF00D;
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    chk_eq("rstwr_wen", 32'(SRAMWEN), 32'h0);
    chk_eq("rstwr_ready", 32'(bus.HREADYOUT), 32'h1);
    chk_eq("rstwr_hrdata", bus.HRDATA, 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;
    q_rd(32'h40, 3'd2);
    run_bus();

    chk_eq("sb_left", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
